// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack instruction
// memory port and presents the fetched instruction with its PC in IF/ID.
// Next-PC operations (branch/jal/jalr) are resolved against the IF/ID slot.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic [2:0]  npc_op,
  input  logic        zero_i,
  input  logic [31:0] npc_imm,
  input  logic [31:0] npc_aluout,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DROP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic [31:0] pc_plus4;
  logic [31:0] stale_addr;
  logic [31:0] stale_addr_next;
  logic        skid_valid;
  logic        skid_valid_next;
  logic [31:0] skid_pc;
  logic [31:0] skid_pc_next;
  logic [31:0] skid_instr;
  logic [31:0] skid_instr_next;
  logic        id_valid_next;
  logic [31:0] id_pc_next;
  logic [31:0] id_instr_next;
  logic        misalign_next;
  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] target;

  assign pc_plus4 = pc + 32'd4;

  // Resolve the control-transfer of the instruction sitting in IF/ID.
  always_comb begin
    raw_target = id_pc + npc_imm;
    if (npc_op == 3'b100) begin
      raw_target = npc_aluout & ~32'h1;
    end
    redirect = id_valid &&
               (((npc_op == 3'b001) && zero_i) ||
                (npc_op == 3'b010) ||
                (npc_op == 3'b100));
    target   = raw_target & ~32'h3;
  end

  // Memory port: DROP keeps the stale address alive until its ack arrives.
  always_comb begin
    imem_req  = (state == REQ) || (state == DROP);
    imem_addr = (state == DROP) ? stale_addr : pc;
  end

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    stale_addr_next = stale_addr;
    skid_valid_next = skid_valid;
    skid_pc_next    = skid_pc;
    skid_instr_next = skid_instr;
    id_valid_next   = id_valid;
    id_pc_next      = id_pc;
    id_instr_next   = id_instr;
    misalign_next   = redirect && raw_target[1];

    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        if (redirect) begin
          pc_next         = target;
          id_valid_next   = 1'b0;
          id_instr_next   = NOP_INSTR;
          skid_valid_next = 1'b0;
          if (!imem_ack) begin
            stale_addr_next = pc;
            state_next      = DROP;
          end
        end else if (imem_ack) begin
          if (!stall_i) begin
            id_valid_next = 1'b1;
            id_pc_next    = pc;
            id_instr_next = imem_rdata;
            pc_next       = pc_plus4;
          end else begin
            skid_valid_next = 1'b1;
            skid_pc_next    = pc;
            skid_instr_next = imem_rdata;
            state_next      = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_next         = target;
          id_valid_next   = 1'b0;
          id_instr_next   = NOP_INSTR;
          skid_valid_next = 1'b0;
          state_next      = REQ;
        end else if (!stall_i) begin
          if (skid_valid) begin
            id_valid_next = 1'b1;
            id_pc_next    = skid_pc;
            id_instr_next = skid_instr;
            pc_next       = pc_plus4;
          end
          skid_valid_next = 1'b0;
          state_next      = REQ;
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and pipeline register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      stale_addr <= RESET_PC;
      skid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= NOP_INSTR;
      id_valid   <= 1'b0;
      id_pc      <= 32'h0;
      id_instr   <= NOP_INSTR;
      misalign_o <= 1'b0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      stale_addr <= stale_addr_next;
      skid_valid <= skid_valid_next;
      skid_pc    <= skid_pc_next;
      skid_instr <= skid_instr_next;
      id_valid   <= id_valid_next;
      id_pc      <= id_pc_next;
      id_instr   <= id_instr_next;
      misalign_o <= misalign_next;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vectors, hand-written multi-cycle sequences and
// a randomized run checked against a transaction-level fetch-stream model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic [2:0]  npc_op;
  logic        zero_i;
  logic [31:0] npc_imm;
  logic [31:0] npc_aluout;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic        misalign_o;

  int tests  = 0;
  int failed = 0;
  int mem_lat = 0;
  int wait_cnt = 0;

  logic        pre_req;
  logic        pre_ack;
  logic [31:0] pre_addr;

  typedef struct {
    logic [31:0] start;
    logic [2:0]  op;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] alu;
    logic        redir;
    logic [31:0] exp_addr;
    logic        mis;
  } vec_t;

  vec_t vecs[9];

  if_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .npc_op(npc_op), .zero_i(zero_i),
    .npc_imm(npc_imm), .npc_aluout(npc_aluout), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {~a[15:0], a[17:2]} ^ 32'h5A5A_0003;
  endfunction

  // Instruction memory: acks after mem_lat wait cycles, same cycle when zero.
  always_comb begin
    imem_ack   = imem_req && (wait_cnt >= mem_lat);
    imem_rdata = imem_ack ? memWord(imem_addr) : 32'hDEAD_BEEF;
  end

  // Count wait cycles of the outstanding request.
  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] op, input logic z,
                               input logic [31:0] imm, input logic [31:0] alu);
    stall_i = s; npc_op = op; zero_i = z; npc_imm = imm; npc_aluout = alu;
    #1;
    pre_req = imem_req; pre_ack = imem_ack; pre_addr = imem_addr;
    @(negedge clk);
  endtask

  task automatic doReset(input int lat);
    mem_lat = lat;
    rst = 1'b1;
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
  endtask

  task automatic waitFill(input logic [31:0] pc, input string name);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (id_valid && id_pc == pc) begin
        found = 1'b1;
        break;
      end
      applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
    end
    checkOutput(name, {31'h0, found}, 32'h1);
  endtask

  // Timeout guard so the run always ends.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  // Main test sequence.
  initial begin
    logic        m_valid;
    logic [31:0] m_pc, m_instr, exp_next, imm, alu, raw;
    logic [2:0]  op;
    logic        s, z, r_rst, d_redir, changed, bad;
    logic [31:0] first_new;
    int          sel, fills, idle_run;

    rst = 1'b0; stall_i = 1'b0; npc_op = 3'b000; zero_i = 1'b0;
    npc_imm = 32'h0; npc_aluout = 32'h0;
    @(negedge clk);

    vecs[0] = '{32'h10, 3'b010, 1'b0, 32'h20,        32'h0,   1'b1, 32'h30,  1'b0};
    vecs[1] = '{32'h40, 3'b001, 1'b0, 32'hFFFF_FFF8, 32'h0,   1'b0, 32'h48,  1'b0};
    vecs[2] = '{32'h40, 3'b001, 1'b1, 32'hFFFF_FFF8, 32'h0,   1'b1, 32'h38,  1'b0};
    vecs[3] = '{32'h08, 3'b100, 1'b0, 32'h0,         32'h103, 1'b1, 32'h100, 1'b1};
    vecs[4] = '{32'h08, 3'b100, 1'b0, 32'h0,         32'h101, 1'b1, 32'h100, 1'b0};
    vecs[5] = '{32'h04, 3'b010, 1'b0, 32'h1E,        32'h0,   1'b1, 32'h20,  1'b1};
    vecs[6] = '{32'h00, 3'b011, 1'b1, 32'h40,        32'h0,   1'b0, 32'h08,  1'b0};
    vecs[7] = '{32'h00, 3'b001, 1'b1, 32'h100,       32'h0,   1'b1, 32'h100, 1'b0};
    vecs[8] = '{32'h0C, 3'b110, 1'b1, 32'h40,        32'h200, 1'b0, 32'h14,  1'b0};

    // Reset values and zero-wait streaming.
    doReset(0);
    checkOutput("rst_valid", {31'h0, id_valid}, 32'h0);
    checkOutput("rst_instr", id_instr, NOP);
    checkOutput("rst_req", {31'h0, imem_req}, 32'h0);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_idpc", id_pc, 32'h0);
    checkOutput("rst_mis", {31'h0, misalign_o}, 32'h0);
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
    checkOutput("first_req", {31'h0, imem_req}, 32'h1);
    checkOutput("first_addr", imem_addr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
      checkOutput($sformatf("stream%0d_addr", k), imem_addr, 32'(4 * (k + 1)));
      checkOutput($sformatf("stream%0d_valid", k), {31'h0, id_valid}, 32'h1);
      checkOutput($sformatf("stream%0d_pc", k), id_pc, 32'(4 * k));
      checkOutput($sformatf("stream%0d_instr", k), id_instr, memWord(32'(4 * k)));
    end

    // Table of next-PC operations under zero-wait memory.
    for (int i = 0; i < 9; i++) begin
      doReset(0);
      waitFill(vecs[i].start, $sformatf("vec%0d_reach", i));
      applyStimulus(1'b0, vecs[i].op, vecs[i].zero, vecs[i].imm, vecs[i].alu);
      checkOutput($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_valid", i), {31'h0, id_valid}, {31'h0, ~vecs[i].redir});
      checkOutput($sformatf("vec%0d_mis", i), {31'h0, misalign_o}, {31'h0, vecs[i].mis});
      applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
      checkOutput($sformatf("vec%0d_pc", i), id_pc, vecs[i].exp_addr);
      checkOutput($sformatf("vec%0d_instr", i), id_instr, memWord(vecs[i].exp_addr));
      checkOutput($sformatf("vec%0d_mis_once", i), {31'h0, misalign_o}, 32'h0);
    end

    // Stall across a slow ack: data parks in the skid, then drains.
    doReset(3);
    waitFill(32'h4, "stall_reach");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 3'b000, 1'b0, 32'h0, 32'h0);
      checkOutput("stall_hold_pc", id_pc, 32'h4);
      if (!imem_req) break;
    end
    checkOutput("hold_req", {31'h0, imem_req}, 32'h0);
    applyStimulus(1'b1, 3'b000, 1'b0, 32'h0, 32'h0);
    applyStimulus(1'b1, 3'b000, 1'b0, 32'h0, 32'h0);
    checkOutput("hold_req2", {31'h0, imem_req}, 32'h0);
    checkOutput("hold_pc2", id_pc, 32'h4);
    checkOutput("hold_valid2", {31'h0, id_valid}, 32'h1);
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
    checkOutput("release_pc", id_pc, 32'h8);
    checkOutput("release_instr", id_instr, memWord(32'h8));
    checkOutput("release_req", {31'h0, imem_req}, 32'h1);
    checkOutput("release_addr", imem_addr, 32'hC);

    // Redirect while a slow request is in flight: the stale data is dropped.
    doReset(4);
    waitFill(32'h20, "drop_reach");
    applyStimulus(1'b0, 3'b010, 1'b0, 32'hE0, 32'h0);
    checkOutput("drop_req", {31'h0, imem_req}, 32'h1);
    checkOutput("drop_stale_addr", imem_addr, 32'h24);
    checkOutput("drop_valid", {31'h0, id_valid}, 32'h0);
    checkOutput("drop_nop", id_instr, NOP);
    bad = 1'b0;
    first_new = 32'h24;
    for (int i = 0; i < 40; i++) begin
      if (id_valid) break;
      if (imem_addr != 32'h24 && first_new == 32'h24) first_new = imem_addr;
      if (id_instr == memWord(32'h24)) bad = 1'b1;
      applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
    end
    checkOutput("drop_next_addr", first_new, 32'h100);
    checkOutput("drop_no_stale", {31'h0, bad}, 32'h0);
    checkOutput("drop_fill_pc", id_pc, 32'h100);
    checkOutput("drop_fill_instr", id_instr, memWord(32'h100));

    // PC wrap from the top of the address space.
    doReset(0);
    waitFill(32'h0, "wrap_reach");
    applyStimulus(1'b0, 3'b010, 1'b0, 32'hFFFF_FFFC, 32'h0);
    checkOutput("wrap_target", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
    checkOutput("wrap_top_pc", id_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    applyStimulus(1'b0, 3'b000, 1'b0, 32'h0, 32'h0);
    checkOutput("wrap_pc0", id_pc, 32'h0);
    checkOutput("wrap_instr0", id_instr, memWord(32'h0));

    // Randomized run against the expected in-order fetch stream.
    doReset(1);
    m_valid = 1'b0; m_pc = 32'h0; m_instr = NOP; exp_next = RESET_PC;
    fills = 0; idle_run = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r_rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 15) == 0) mem_lat = $urandom_range(0, 3);
      s = ($urandom_range(0, 3) == 0);
      z = $urandom_range(0, 1) == 1;
      sel = $urandom_range(0, 11);
      case (sel)
        0: op = 3'b010;
        1: op = 3'b001;
        2: op = 3'b100;
        3: op = 3'($urandom_range(0, 7));
        default: op = 3'b000;
      endcase
      imm = 32'($urandom_range(1, 64)) << 2;
      if ($urandom_range(0, 1) == 1) imm = -imm;
      if ($urandom_range(0, 7) == 0) imm = imm ^ 32'h2;
      alu = $urandom;
      d_redir = m_valid && (((op == 3'b001) && z) || op == 3'b010 || op == 3'b100);
      raw = (op == 3'b100) ? (alu & ~32'h1) : (m_pc + imm);
      rst = r_rst;
      applyStimulus(s, op, z, imm, alu);
      rst = 1'b0;

      if (r_rst) begin
        checkOutput("rnd_rst_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("rnd_rst_instr", id_instr, NOP);
        checkOutput("rnd_rst_req", {31'h0, imem_req}, 32'h0);
        checkOutput("rnd_rst_addr", imem_addr, RESET_PC);
        checkOutput("rnd_rst_mis", {31'h0, misalign_o}, 32'h0);
        m_valid = 1'b0; m_pc = 32'h0; m_instr = NOP; exp_next = RESET_PC;
        idle_run = 0;
        continue;
      end

      checkOutput("rnd_mis", {31'h0, misalign_o}, {31'h0, d_redir && raw[1]});
      if (pre_req && !pre_ack) begin
        checkOutput("rnd_req_kept", {31'h0, imem_req}, 32'h1);
        checkOutput("rnd_addr_stable", imem_addr, pre_addr);
      end
      if (imem_req) checkOutput("rnd_addr_align", {30'h0, imem_addr[1:0]}, 32'h0);

      changed = 1'b0;
      if (d_redir) begin
        checkOutput("rnd_redir_valid", {31'h0, id_valid}, 32'h0);
        checkOutput("rnd_redir_nop", id_instr, NOP);
        m_valid = 1'b0; m_instr = NOP;
        exp_next = raw & ~32'h3;
      end else if (s) begin
        checkOutput("rnd_stall_valid", {31'h0, id_valid}, {31'h0, m_valid});
        checkOutput("rnd_stall_pc", id_pc, m_pc);
        checkOutput("rnd_stall_instr", id_instr, m_instr);
      end else begin
        changed = id_valid && (!m_valid || id_pc !== m_pc || id_instr !== m_instr);
        if (changed) begin
          checkOutput("rnd_fill_pc", id_pc, exp_next);
          checkOutput("rnd_fill_instr", id_instr, memWord(exp_next));
          m_valid = 1'b1; m_pc = exp_next; m_instr = memWord(exp_next);
          exp_next = exp_next + 32'd4;
          fills++;
        end else if (!id_valid) begin
          checkOutput("rnd_no_bubble", {31'h0, id_valid}, {31'h0, m_valid});
          checkOutput("rnd_bubble_nop", id_instr, NOP);
        end
      end

      if (changed || d_redir) idle_run = 0;
      else idle_run++;
      if (idle_run > 300) begin
        tests++; failed++;
        $display("[TB] FAIL rnd_progress: got %0d idle cycles expected at most 300", idle_run);
        break;
      end
    end
    checkOutput("rnd_fill_count", {31'h0, fills > 100}, 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
